// File: rtl/lmc1992.sv
// LMC1992-style volume/tone controller and DMA/PSG mixer for the STE audio path.
// Decodes microwire command words and applies master plus per-channel attenuation.
module lmc1992 #(
  parameter int GAIN_W = 9
) (
  input  logic              clk32,
  input  logic              reset,
  input  logic              bit_stb,
  input  logic              mw_clk,
  input  logic              mw_data,
  input  logic              mw_done,
  input  logic [7:0]        dma_left,
  input  logic [7:0]        dma_right,
  input  logic [7:0]        psg,
  output logic signed [9:0] audio_l,
  output logic signed [9:0] audio_r,
  output logic [3:0]        bass,
  output logic [3:0]        treble,
  output logic [1:0]        mix
);

  logic [10:0] sr_q, sr_d, sr_shift;
  logic [3:0]  cnt_q, cnt_d, cnt_shift;
  logic [5:0]  master_q, master_d;
  logic [4:0]  left_q, left_d, right_q, right_d;
  logic [3:0]  bass_q, bass_d, treble_q, treble_d;
  logic [1:0]  mix_q, mix_d;

  logic signed [8:0]  sum_l_q, sum_l_d, sum_r_q, sum_r_d;
  logic [GAIN_W-1:0]  gain_l_q, gain_l_d, gain_r_q, gain_r_d;
  logic signed [9:0]  audio_l_q, audio_l_d, audio_r_q, audio_r_d;

  logic signed [9:0]  s_dma_l, s_dma_r, s_psg, psg_term, sum_l10, sum_r10;
  logic [5:0]         master_c;
  logic [4:0]         left_c, right_c;
  logic [6:0]         steps_l, steps_r;
  logic signed [18:0] prod_l, prod_r;

  // 2 dB attenuation steps: round(256 * 10^(-n/10)), zero from step 28 on
  function automatic logic [GAIN_W-1:0] gain_rom(input logic [6:0] n);
    logic [GAIN_W-1:0] g;
    case (n)
      7'd0:  g = GAIN_W'(256);
      7'd1:  g = GAIN_W'(203);
      7'd2:  g = GAIN_W'(162);
      7'd3:  g = GAIN_W'(128);
      7'd4:  g = GAIN_W'(102);
      7'd5:  g = GAIN_W'(81);
      7'd6:  g = GAIN_W'(64);
      7'd7:  g = GAIN_W'(51);
      7'd8:  g = GAIN_W'(41);
      7'd9:  g = GAIN_W'(32);
      7'd10: g = GAIN_W'(26);
      7'd11: g = GAIN_W'(20);
      7'd12: g = GAIN_W'(16);
      7'd13: g = GAIN_W'(13);
      7'd14: g = GAIN_W'(10);
      7'd15: g = GAIN_W'(8);
      7'd16: g = GAIN_W'(6);
      7'd17: g = GAIN_W'(5);
      7'd18: g = GAIN_W'(4);
      7'd19: g = GAIN_W'(3);
      7'd20: g = GAIN_W'(3);
      7'd21: g = GAIN_W'(2);
      7'd22: g = GAIN_W'(2);
      7'd23: g = GAIN_W'(1);
      7'd24: g = GAIN_W'(1);
      7'd25: g = GAIN_W'(1);
      7'd26: g = GAIN_W'(1);
      7'd27: g = GAIN_W'(1);
      default: g = '0;
    endcase
    return g;
  endfunction

  // Decode sees the shift of a bit that arrives in the same cycle as mw_done
  always_comb begin
    sr_shift  = sr_q;
    cnt_shift = cnt_q;
    if (bit_stb && mw_clk) begin
      sr_shift = {sr_q[9:0], mw_data};
      if (cnt_q != 4'd15) cnt_shift = cnt_q + 4'd1;
    end

    sr_d     = sr_shift;
    cnt_d    = cnt_shift;
    master_d = master_q;
    left_d   = left_q;
    right_d  = right_q;
    bass_d   = bass_q;
    treble_d = treble_q;
    mix_d    = mix_q;

    if (mw_done) begin
      cnt_d = 4'd0;
      if (cnt_shift >= 4'd11 && sr_shift[10:9] == 2'b10) begin
        case (sr_shift[8:6])
          3'b000:  mix_d    = sr_shift[1:0];
          3'b001:  bass_d   = sr_shift[3:0];
          3'b010:  treble_d = sr_shift[3:0];
          3'b011:  master_d = sr_shift[5:0];
          3'b100:  right_d  = sr_shift[4:0];
          3'b101:  left_d   = sr_shift[4:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    s_dma_l  = $signed({2'b00, dma_left})  - 10'sd128;
    s_dma_r  = $signed({2'b00, dma_right}) - 10'sd128;
    s_psg    = $signed({2'b00, psg})       - 10'sd128;
    psg_term = s_psg >>> 2;

    case (mix_q)
      2'b00: begin
        sum_l10 = s_dma_l + psg_term;
        sum_r10 = s_dma_r + psg_term;
      end
      2'b01: begin
        sum_l10 = s_dma_l + s_psg;
        sum_r10 = s_dma_r + s_psg;
      end
      default: begin
        sum_l10 = s_dma_l;
        sum_r10 = s_dma_r;
      end
    endcase
    sum_l_d = 9'(sum_l10);
    sum_r_d = 9'(sum_r10);

    // Stored values are clamped only where they are used
    master_c = (master_q > 6'd40) ? 6'd40 : master_q;
    left_c   = (left_q   > 5'd20) ? 5'd20 : left_q;
    right_c  = (right_q  > 5'd20) ? 5'd20 : right_q;
    steps_l  = (7'd40 - {1'b0, master_c}) + (7'd20 - {2'b00, left_c});
    steps_r  = (7'd40 - {1'b0, master_c}) + (7'd20 - {2'b00, right_c});
    gain_l_d = gain_rom(steps_l);
    gain_r_d = gain_rom(steps_r);
  end

  always_comb begin
    prod_l    = 19'(sum_l_q) * 19'($signed({1'b0, gain_l_q}));
    prod_r    = 19'(sum_r_q) * 19'($signed({1'b0, gain_r_q}));
    audio_l_d = 10'(prod_l >>> 8);
    audio_r_d = 10'(prod_r >>> 8);
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      master_q  <= 6'd40;
      left_q    <= 5'd20;
      right_q   <= 5'd20;
      bass_q    <= 4'd6;
      treble_q  <= 4'd6;
      mix_q     <= 2'b01;
      sum_l_q   <= '0;
      sum_r_q   <= '0;
      gain_l_q  <= '0;
      gain_r_q  <= '0;
      audio_l_q <= '0;
      audio_r_q <= '0;
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      master_q  <= master_d;
      left_q    <= left_d;
      right_q   <= right_d;
      bass_q    <= bass_d;
      treble_q  <= treble_d;
      mix_q     <= mix_d;
      sum_l_q   <= sum_l_d;
      sum_r_q   <= sum_r_d;
      gain_l_q  <= gain_l_d;
      gain_r_q  <= gain_r_d;
      audio_l_q <= audio_l_d;
      audio_r_q <= audio_r_d;
    end
  end

  assign audio_l = audio_l_q;
  assign audio_r = audio_r_q;
  assign bass    = (bass_q   > 4'd12) ? 4'd12 : bass_q;
  assign treble  = (treble_q > 4'd12) ? 4'd12 : treble_q;
  assign mix     = mix_q;

endmodule

// File: doc/lmc1992.md
# lmc1992

Volume/tone control and final audio mixer in the STE audio path, modelled on the National LMC1992. Consumes the microwire serial stream from the shifter's microwire master (`mw_clk`/`mw_data`/`mw_done`) and decodes LMC1992 command words. Mixes the shifter's DMA sound bytes with the YM/PSG output and applies combined master and per-channel attenuation. Bass and treble settings are stored and exported for a downstream tone filter; this block does not filter.

## Interface
Parameters:
- `GAIN_W`, 9: width of the unsigned gain word (256 = 0 dB).

Ports:
- `clk32`  in  1  system clock, 32 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `bit_stb`  in  1  one-cycle pulse: `mw_clk`/`mw_data` hold a new bit slot.
- `mw_clk`  in  1  mask bit; the slot is a valid data bit only when 1.
- `mw_data`  in  1  serial data bit, MSB first.
- `mw_done`  in  1  one-cycle pulse: end of the microwire transfer.
- `dma_left`, `dma_right`  in  8 each  DMA sound samples, unsigned, offset 128.
- `psg`  in  8  PSG audio, unsigned, offset 128.
- `audio_l`, `audio_r`  out  10 each  signed mixed and attenuated output.
- `bass`, `treble`  out  4 each  tone settings, 0..12, 6 = flat.
- `mix`  out  2  current mixing mode.

## Operation
- Decided: one clock `clk32`; reset `reset` is synchronous and active-high.
- Receiver:
  - On `bit_stb & mw_clk`: `sr <= {sr[9:0], mw_data}` (11-bit shift register); `cnt` increments, saturating at 15.
  - Slots with `mw_clk=0` are ignored.
- On `mw_done`:
  - If `cnt >= 11` and `sr[10:9] == 2'b10`, decode `reg = sr[8:6]` and `d = sr[5:0]`.
  - Decode map: 000 mix <= d[1:0]; 001 bass <= d[3:0]; 010 treble <= d[3:0]; 011 master <= d; 100 right <= d[4:0]; 101 left <= d[4:0].
  - Registers 110 and 111 are ignored.
  - `cnt <= 0` in every case. A wrong address or a short word changes no register.
  - When `bit_stb` and `mw_done` arrive in the same cycle, the bit is shifted in first and the decode includes it.
- Value clamps, applied at use and not at storage: master > 40 → 40; left/right > 20 → 20; bass/treble > 12 → 12 at the outputs.
- Attenuation:
  - `steps_x = (40 - master_c) + (20 - chan_c)`, giving 0..60 steps of 2 dB.
  - `gain = ROM[steps]`, where `ROM[n] = round(256 * 10^(-n/10))`.
  - Examples: ROM[0]=256, ROM[1]=203, ROM[5]=81, ROM[10]=26, and 0 for n ≥ 28.
- Mixing. All values are signed; `s(x) = x - 128`.
  - mix 00: `sum = s(dma) + (s(psg) >>> 2)`, i.e. PSG at −12 dB.
  - mix 01: `sum = s(dma) + s(psg)`.
  - mix 10 and 11: `sum = s(dma)`.
  - `sum` is 9-bit signed, range −256..254. It cannot overflow.
- Output: `audio_x = (sum * gain) >>> 8`.
  - Signed 9 × unsigned 9 product; arithmetic shift, which floors toward −∞.
  - Result is 10-bit signed. At gain 256, `audio_x == sum`.

## Timing
- Reset values:
  - Outputs: `audio_l = audio_r = 0`.
  - Registers: master 40, left 20, right 20, bass 6, treble 6, mix 01.
  - Receiver: sr = 0, cnt = 0.
  - Reset mid-transfer discards the partial word.
- Register write: the new value is visible on `bass`/`treble`/`mix` on the edge after `mw_done`.
- Audio pipeline:
  - Stage 1 registers `sum` and `gain`; stage 2 registers the outputs.
  - Latency is 2 `clk32` edges from a change on `dma_*`/`psg`.
  - After a volume write, the new gain reaches the output 3 edges after `mw_done`.
- The pipeline runs every cycle with no enable. Inputs are sampled every cycle, so upstream holds samples stable between its update strobes.
- No handshake back to the microwire master. The block always accepts.

## Test plan
- Reset: assert `reset` for 2 cycles with dma=200, psg=50.
  - During reset: audio 0; bass=6, treble=6, mix=01.
  - Three cycles after release: audio = (72 + (−78)) = −6 on both channels.
- Master write: send 11 bits `10 011 100011` (master 35), then `mw_done`. Drive dma=228, psg=128.
  - Steps = 5, gain = 81, so `audio_l = (100*81)>>>8 = 31`.
  - With dma=28: result is −32 (floor of −31.64).
- Mask: send 16 slots with mask 0x07FF carrying `00000` then `10 101 010000` (left 16), followed by `mw_done`.
  - The first 5 slots are ignored and left = 16.
  - Steps for left = 4, gain = 102, so dma=228 gives `audio_l = 39` while `audio_r` stays 100.
- Rejection:
  - Address `01` with valid payload: no change.
  - 10-bit word then `mw_done`: no change, and cnt returns to 0.
  - A following correct word is decoded normally.
- Mix modes:
  - mix 00, dma=128, psg=255: audio = 31.
  - mix 10 with the same inputs: audio = 0.
  - mix 01, dma=255, psg=255: audio = 254.
  - mix 01, dma=0, psg=0: audio = −256.
- Clamp and simultaneity: write master 63 with the final bit's `bit_stb` coincident with `mw_done`.
  - Register decoded and treated as 40, so gain = 256 and audio equals sum.
  - Bass write of 15 reads back as 12 on `bass`.
